// File: rtl/fcmp_pipe.sv
// Two-stage pipelined FP compare / min-max stage (FEQ/FLT/FLE/FMIN/FMAX) around fcmp_core.
// Define FCMP_CLASS_EN to add FCLASS on op 5; otherwise op 5 is treated as reserved.
module fcmp_pipe #(
  parameter int unsigned EXPWIDTH  = 8,
  parameter int unsigned PRECISION = 24,
  parameter int unsigned CTRLWIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [2:0]                    op_i,
  input  logic [EXPWIDTH+PRECISION-1:0] a_i,
  input  logic [EXPWIDTH+PRECISION-1:0] b_i,
  input  logic [CTRLWIDTH-1:0]          ctrl_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [EXPWIDTH+PRECISION-1:0] result_o,
  output logic [4:0]                    fflags_o,
  output logic [CTRLWIDTH-1:0]          ctrl_o
);
  localparam int unsigned W = EXPWIDTH + PRECISION;
  localparam int unsigned F = PRECISION - 1;

  typedef enum logic [2:0] {
    OP_FEQ    = 3'd0,
    OP_FLT    = 3'd1,
    OP_FLE    = 3'd2,
    OP_FMIN   = 3'd3,
    OP_FMAX   = 3'd4,
    OP_FCLASS = 3'd5
  } op_e;

  logic                 r_s1_valid, r_s2_valid;
  logic [2:0]           r_op;
  logic [W-1:0]         r_a, r_b, r_res;
  logic [CTRLWIDTH-1:0] r_ctrl1, r_ctrl2;
  logic [4:0]           r_flags;

  logic         w_s1_en, w_s2_en;
  logic         w_sig, w_eq, w_le, w_lt;
  logic [4:0]   w_cflags, w_flags;
  logic [W-1:0] w_res, w_qnan;
  logic         w_a_nan, w_b_nan, w_both_zero, w_is_min;

  assign w_s2_en     = !r_s2_valid || out_ready_i;
  assign w_s1_en     = !r_s1_valid || w_s2_en;
  assign in_ready_o  = w_s1_en;
  assign out_valid_o = r_s2_valid;
  assign result_o    = r_res;
  assign fflags_o    = r_flags;
  assign ctrl_o      = r_ctrl2;

  assign w_sig = (r_op == OP_FLT) || (r_op == OP_FLE);

  fcmp_core #(
    .EXPWIDTH (EXPWIDTH),
    .PRECISION(PRECISION)
  ) u_core (
    .a_i        (r_a),
    .b_i        (r_b),
    .signaling_i(w_sig),
    .eq_o       (w_eq),
    .le_o       (w_le),
    .lt_o       (w_lt),
    .fflags_o   (w_cflags)
  );

  assign w_a_nan     = (&r_a[W-2:F]) && (|r_a[F-1:0]);
  assign w_b_nan     = (&r_b[W-2:F]) && (|r_b[F-1:0]);
  assign w_both_zero = (r_a[W-2:0] == '0) && (r_b[W-2:0] == '0);
  assign w_is_min    = (r_op == OP_FMIN);
  assign w_qnan      = {1'b0, {EXPWIDTH{1'b1}}, 1'b1, {(PRECISION-2){1'b0}}};

`ifdef FCMP_CLASS_EN
  logic       w_exp_one, w_exp_zero, w_frac_zero, w_sgn;
  logic [9:0] w_class;
  assign w_sgn       = r_a[W-1];
  assign w_exp_one   = &r_a[W-2:F];
  assign w_exp_zero  = ~|r_a[W-2:F];
  assign w_frac_zero = ~|r_a[F-1:0];
  assign w_class = {
    w_exp_one && !w_frac_zero && r_a[F-1],
    w_exp_one && !w_frac_zero && !r_a[F-1],
    !w_sgn && w_exp_one && w_frac_zero,
    !w_sgn && !w_exp_one && !w_exp_zero,
    !w_sgn && w_exp_zero && !w_frac_zero,
    !w_sgn && w_exp_zero && w_frac_zero,
    w_sgn && w_exp_zero && w_frac_zero,
    w_sgn && w_exp_zero && !w_frac_zero,
    w_sgn && !w_exp_one && !w_exp_zero,
    w_sgn && w_exp_one && w_frac_zero
  };
`endif

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    case (r_op)
      OP_FEQ: begin
        w_res   = {{(W-1){1'b0}}, w_eq};
        w_flags = w_cflags;
      end
      OP_FLT: begin
        w_res   = {{(W-1){1'b0}}, w_lt};
        w_flags = w_cflags;
      end
      OP_FLE: begin
        w_res   = {{(W-1){1'b0}}, w_le};
        w_flags = w_cflags;
      end
      OP_FMIN, OP_FMAX: begin
        w_flags = w_cflags;
        if (w_a_nan && w_b_nan)   w_res = w_qnan;
        else if (w_a_nan)         w_res = r_b;
        else if (w_b_nan)         w_res = r_a;
        // Signed zeros compare equal, so pick by sign: min wants the negative one.
        else if (w_both_zero)     w_res = (w_is_min == r_a[W-1]) ? r_a : r_b;
        else if (w_is_min)        w_res = w_lt ? r_a : r_b;
        else                      w_res = w_le ? r_b : r_a;
      end
`ifdef FCMP_CLASS_EN
      OP_FCLASS: w_res = {{(W-10){1'b0}}, w_class};
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_ctrl1    <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid_i;
      if (in_valid_i) begin
        r_op    <= op_i;
        r_a     <= a_i;
        r_b     <= b_i;
        r_ctrl1 <= ctrl_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_res      <= '0;
      r_flags    <= '0;
      r_ctrl2    <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res   <= w_res;
        r_flags <= w_flags;
        r_ctrl2 <= r_ctrl1;
      end
    end
  end
endmodule

// IEEE-754 comparator: quiet/signaling eq, le, lt with NV flag generation.
module fcmp_core #(
  parameter int unsigned EXPWIDTH  = 8,
  parameter int unsigned PRECISION = 24
) (
  input  logic [EXPWIDTH+PRECISION-1:0] a_i,
  input  logic [EXPWIDTH+PRECISION-1:0] b_i,
  input  logic                          signaling_i,
  output logic                          eq_o,
  output logic                          le_o,
  output logic                          lt_o,
  output logic [4:0]                    fflags_o
);
  localparam int unsigned W = EXPWIDTH + PRECISION;
  localparam int unsigned F = PRECISION - 1;

  logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_any_nan, w_any_snan;
  logic w_both_zero, w_mag_lt, w_mag_gt, w_eq_raw, w_lt_raw, w_nv;

  assign w_a_nan     = (&a_i[W-2:F]) && (|a_i[F-1:0]);
  assign w_b_nan     = (&b_i[W-2:F]) && (|b_i[F-1:0]);
  assign w_a_snan    = w_a_nan && !a_i[F-1];
  assign w_b_snan    = w_b_nan && !b_i[F-1];
  assign w_any_nan   = w_a_nan || w_b_nan;
  assign w_any_snan  = w_a_snan || w_b_snan;
  assign w_both_zero = (a_i[W-2:0] == '0) && (b_i[W-2:0] == '0);
  assign w_mag_lt    = a_i[W-2:0] < b_i[W-2:0];
  assign w_mag_gt    = a_i[W-2:0] > b_i[W-2:0];
  assign w_eq_raw    = (a_i == b_i) || w_both_zero;

  // Sign-magnitude ordering: negative magnitudes compare inverted.
  always_comb begin
    if (a_i[W-1] != b_i[W-1]) w_lt_raw = a_i[W-1] && !w_both_zero;
    else if (a_i[W-1])        w_lt_raw = w_mag_gt;
    else                      w_lt_raw = w_mag_lt;
  end

  assign w_nv     = signaling_i ? w_any_nan : w_any_snan;
  assign eq_o     = !w_any_nan && w_eq_raw;
  assign lt_o     = !w_any_nan && w_lt_raw;
  assign le_o     = !w_any_nan && (w_lt_raw || w_eq_raw);
  assign fflags_o = {w_nv, 4'b0000};
endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed self-checking bench for fcmp_pipe: per-op results, NaN/zero cases, stall stream, reset flush.
module tb_fcmp_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i, result_o;
  logic [15:0] ctrl_i, ctrl_o;
  logic [4:0]  fflags_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fcmp_pipe #(
    .EXPWIDTH (8),
    .PRECISION(24),
    .CTRLWIDTH(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .ctrl_i     (ctrl_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o),
    .fflags_o   (fflags_o),
    .ctrl_o     (ctrl_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one request to an empty pipe and checks latency, result and single delivery.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] c,
                        input logic [31:0] er, input logic [4:0] ef);
    int unsigned lat;
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; ctrl_i = c;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    #1;
    check({tag, "_in_ready"}, {31'd0, in_ready_o}, 32'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      lat++;
    end while (!out_valid_o && lat < 8);
    check({tag, "_latency"}, lat, 32'd2);
    check({tag, "_result"}, result_o, er);
    check({tag, "_fflags"}, {27'd0, fflags_o}, {27'd0, ef});
    check({tag, "_ctrl"}, {16'd0, ctrl_o}, {16'd0, c});
    @(posedge clk); #1;
    check({tag, "_drained"}, {31'd0, out_valid_o}, 32'd0);
  endtask

  logic [2:0]  s_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd1, 3'd0};
  logic [31:0] s_a   [8] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40400000,
                             32'hBF800000, 32'hC0000000, 32'hC0000000, 32'h7FC00000};
  logic [31:0] s_b   [8] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000,
                             32'h3F800000, 32'hBF800000, 32'hBF800000, 32'h7FC00000};
  logic [31:0] s_exp [8] = '{32'h1, 32'h0, 32'h1, 32'h40000000,
                             32'h3F800000, 32'hC0000000, 32'h1, 32'h0};
  logic        pat   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int sent, recv, cyc, inflight;
    logic in_fire, out_fire;
    rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0; ctrl_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_fflags", {27'd0, fflags_o}, 32'd0);
    check("rst_ctrl", {16'd0, ctrl_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);

    run_op("flt",      3'd1, 32'h3F800000, 32'h40000000, 16'h0A5A, 32'h00000001, 5'h00);
    run_op("feq_zero", 3'd0, 32'h00000000, 32'h80000000, 16'h0001, 32'h00000001, 5'h00);
    run_op("fle_qnan", 3'd2, 32'h7FC00000, 32'h3F800000, 16'h0002, 32'h00000000, 5'h10);
    run_op("feq_qnan", 3'd0, 32'h7FC00000, 32'h3F800000, 16'h0003, 32'h00000000, 5'h00);
    run_op("fmin_snan", 3'd3, 32'h7F800001, 32'hBF800000, 16'h0004, 32'hBF800000, 5'h10);
    run_op("fmax_2qnan", 3'd4, 32'h7FC00000, 32'h7FC00000, 16'h0005, 32'h7FC00000, 5'h00);
    run_op("fmin_pz_nz", 3'd3, 32'h00000000, 32'h80000000, 16'h0006, 32'h80000000, 5'h00);
    run_op("fmax_pz_nz", 3'd4, 32'h00000000, 32'h80000000, 16'h0007, 32'h00000000, 5'h00);
    run_op("fmin_nz_pz", 3'd3, 32'h80000000, 32'h00000000, 16'h0008, 32'h80000000, 5'h00);
    run_op("fmax_nz_pz", 3'd4, 32'h80000000, 32'h00000000, 16'h0009, 32'h00000000, 5'h00);
    run_op("reserved7", 3'd7, 32'h3F800000, 32'h40000000, 16'hBEEF, 32'h00000000, 5'h00);
`ifdef FCMP_CLASS_EN
    run_op("fclass_ninf", 3'd5, 32'hFF800000, 32'h12345678, 16'h00C1, 32'h00000001, 5'h00);
    run_op("fclass_qnan", 3'd5, 32'h7FC00000, 32'h00000000, 16'h00C2, 32'h00000200, 5'h00);
`else
    run_op("op5_reserved", 3'd5, 32'hFF800000, 32'h12345678, 16'h00C1, 32'h00000000, 5'h00);
`endif

    // Back-to-back stream with out_ready cycling 1,0,0,1.
    sent = 0; recv = 0; cyc = 0;
    while (recv < 8 && cyc < 80) begin
      @(negedge clk);
      out_ready_i = pat[cyc % 4];
      if (sent < 8) begin
        op_i = s_op[sent]; a_i = s_a[sent]; b_i = s_b[sent];
        ctrl_i = 16'h0100 + 16'(sent); in_valid_i = 1'b1;
      end else begin
        in_valid_i = 1'b0;
      end
      #1;
      inflight = sent - recv;
      check("stream_in_ready", {31'd0, in_ready_o}, {31'd0, (inflight < 2) || out_ready_i});
      if (out_valid_o && recv < 8) begin
        check("stream_result", result_o, s_exp[recv]);
        check("stream_ctrl", {16'd0, ctrl_o}, 32'h0100 + 32'(recv));
      end
      in_fire  = in_valid_i && in_ready_o;
      out_fire = out_valid_o && out_ready_i;
      if (in_fire) sent++;
      if (out_fire) recv++;
      cyc++;
    end
    check("stream_count", 32'(recv), 32'd8);
    @(negedge clk);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stream_no_extra", {31'd0, out_valid_o}, 32'd0);

    // Two requests in flight, stalled, then reset mid-operation.
    @(negedge clk);
    out_ready_i = 1'b0; in_valid_i = 1'b1;
    op_i = 3'd4; a_i = 32'h3F800000; b_i = 32'h40000000; ctrl_i = 16'h0D01;
    @(negedge clk);
    ctrl_i = 16'h0D02;
    @(negedge clk);
    in_valid_i = 1'b0;
    check("flush_pre_valid", {31'd0, out_valid_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("flush_valid", {31'd0, out_valid_o}, 32'd0);
    check("flush_result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_output", {31'd0, out_valid_o}, 32'd0);
    run_op("fmax_after_rst", 3'd4, 32'h40400000, 32'h40000000, 16'h0E0E, 32'h40400000, 5'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fcmp_pipe.md
Name: fcmp_pipe

Overview:
- Pipelined floating-point compare/min-max stage inside the SM FPU.
- Accepts an operand pair plus opcode and control tag over a valid/ready handshake.
- Evaluates the pair with one instance of the existing fcmp_core (eq/le/lt/fflags).
- Produces FEQ/FLT/FLE/FMIN/FMAX results with IEEE-754/RISC-V NaN semantics to the FPU writeback arbiter, at a fixed 2-cycle latency with full backpressure.

Parameters:
- EXPWIDTH, 8, exponent width; passed to fcmp_core.
- PRECISION, 24, significand width including hidden bit; passed to fcmp_core.
- CTRLWIDTH, 16, width of the opaque control tag (warp id, rd, etc.) carried alongside data.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid_i  input  1  request valid
- in_ready_o  output  1  stage can accept request
- op_i  input  3  0=FEQ 1=FLT 2=FLE 3=FMIN 4=FMAX 5=FCLASS (only with FCMP_CLASS_EN); others reserved
- a_i  input  EXPWIDTH+PRECISION  operand a
- b_i  input  EXPWIDTH+PRECISION  operand b
- ctrl_i  input  CTRLWIDTH  control tag
- out_valid_o  output  1  result valid
- out_ready_i  input  1  downstream accepts result
- result_o  output  EXPWIDTH+PRECISION  result word
- fflags_o  output  5  {NV,DZ,OF,UF,NX}
- ctrl_o  output  CTRLWIDTH  tag returned with result

Behaviour:
- Reset is asynchronous on rst_n low. While reset is asserted: all valid bits, result_o, fflags_o and ctrl_o are 0, and in_ready_o is 1 after reset.
- Pipeline: S1 registers op/a/b/ctrl on accept. S2 registers the computed result/fflags/ctrl. out_valid_o is driven from S2.
- Latency: a request accepted at edge N presents out_valid_o after edge N+2 if no stall occurs.
- Handshake:
  - Transfer occurs when valid && ready.
  - s2_en = !s2_valid || out_ready_i.
  - s1_en = !s1_valid || s2_en.
  - in_ready_o = s1_en (combinational from out_ready_i; no skid buffer).
  - Sustained throughput is 1 request/cycle.
  - While out_valid_o=1 and out_ready_i=0, S2 contents are held stable.
- Bubbles: s1_valid and s2_valid clear when their stage advances with no incoming valid.
- fcmp_core signaling_i is 1 for FLT/FLE and 0 for all other ops.
- FEQ/FLT/FLE: result_o = {0..., eq|lt|le} respectively; fflags_o = core fflags.
- FMIN/FMAX:
  - If both operands are NaN, result = canonical qNaN (sign 0, exponent all ones, MSB of fraction 1, rest 0).
  - If exactly one operand is NaN, result = the other operand.
  - Otherwise FMIN selects a when lt, FMAX selects a when !le; the other operand is selected in the remaining case.
  - For signed zeros: FMIN(+0,-0) = -0 and FMAX(-0,+0) = +0, resolved by sign bit when both are zero, in either operand order.
  - NV is set only for an sNaN input.
- Reserved op: result 0, fflags 0, and the tag still flows so the warp is not lost.
- The tag is carried unchanged alongside data at every stage.
- Mid-operation reset discards all in-flight entries; no output is produced for them.

Optional Feature:
- Macro: FCMP_CLASS_EN.
- When defined, op 5 = FCLASS. result_o[9:0] is a one-hot class: {qNaN, sNaN, +inf, +normal, +subnormal, +0, -0, -subnormal, -normal, -inf}, bit9 down to bit0. Upper bits are 0, fflags are 0, and b_i is ignored.
- When undefined, op 5 is reserved and behaves as described above; no classify logic is synthesized.

Test Plan:
- FLT a=0x3F800000 b=0x40000000, ctrl=0x0A5A, out_ready=1 -> two cycles later result 0x00000001, fflags 0, ctrl 0x0A5A.
- FEQ a=0x00000000 b=0x80000000 -> result 1, fflags 0. FLE a=0x7FC00000 b=0x3F800000 -> result 0, fflags 0x10.
- FMIN a=0x7F800001 (sNaN) b=0xBF800000 -> result 0xBF800000, fflags 0x10. FMAX with both qNaN -> 0x7FC00000, fflags 0.
- FMIN a=0x00000000 b=0x80000000 -> 0x80000000. FMAX with the same operands -> 0x00000000.
- Back-to-back stream of 8 requests with out_ready toggling 1,0,0,1 -> results arrive in order with no drops or duplicates, outputs are held while stalled, and in_ready_o=0 whenever both stages are full and out_ready_i=0.
- Assert rst_n low with two requests in flight -> out_valid_o=0 immediately. After release, a new FMAX 0x40400000 vs 0x40000000 returns 0x40400000. With FCMP_CLASS_EN, FCLASS on 0xFF800000 -> 0x001.
